// File: rtl/cache_ctrl_2way_if.sv
// CPU-side request/response bundle for the 2-way cache controller.
//   master (CPU)   : drives req_valid, req_write, req_addr; sees req_ready, resp_valid, resp_hit
//   slave  (cache) : the mirror image
interface cache_ctrl_2way_if #(
  parameter int ADDR_W = 5
);
  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              resp_valid;
  logic              resp_hit;

  modport master (
    output req_valid, req_write, req_addr,
    input  req_ready, resp_valid, resp_hit
  );

  modport slave (
    input  req_valid, req_write, req_addr,
    output req_ready, resp_valid, resp_hit
  );
endinterface

// File: rtl/cache_ctrl_2way.sv
// Sequencer for a 2-way set-associative, write-back, write-allocate cache
// sitting in front of a single-port RAM. Owns tag/valid/dirty/LRU metadata and
// drives the data-array and RAM control; data words travel through the
// external datapath muxes.
// Ports:
//   clock, reset_n  : clock and asynchronous active-low reset
//   bus (slave)     : CPU valid/ready request, one-cycle response pulse + hit flag
//   arr_we/arr_src/arr_set/arr_way : data-array write enable, source (0 CPU, 1 RAM q), set, way
//   ram_addr/ram_wren/write_back   : RAM address and write-back strobe
//   state, lru, valid_o, dirty_o   : observability of FSM state and metadata
module cache_ctrl_2way #(
  parameter int RAM_LAT = 2,
  parameter int ADDR_W  = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  cache_ctrl_2way_if.slave  bus,
  output logic              arr_we,
  output logic              arr_src,
  output logic [1:0]        arr_set,
  output logic              arr_way,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic              write_back,
  output logic [2:0]        state,
  output logic [3:0]        lru,
  output logic [7:0]        valid_o,
  output logic [7:0]        dirty_o
);
  localparam int TAG_W = ADDR_W - 2;
  localparam int CNT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    WB     = 3'd2,
    FILL   = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] addr_q_r;
  logic              write_q_r;
  logic              miss_r;
  logic              victim_r;
  logic              hit_way_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [TAG_W-1:0]  tag_r [8];   // indexed by {set, way}
  logic [7:0]        valid_r;
  logic [7:0]        dirty_r;
  logic [3:0]        lru_r;

  logic [1:0]        set_s;
  logic [TAG_W-1:0]  tagq_s;
  logic [2:0]        idx0_s, idx1_s, vic_idx_s, new_vic_idx_s;
  logic              hit0_s, hit1_s, hit_s, hit_way_s, victim_s, last_s;

  assign set_s         = addr_q_r[1:0];
  assign tagq_s        = addr_q_r[ADDR_W-1:2];
  assign idx0_s        = {set_s, 1'b0};
  assign idx1_s        = {set_s, 1'b1};
  assign hit0_s        = valid_r[idx0_s] && (tag_r[idx0_s] == tagq_s);
  assign hit1_s        = valid_r[idx1_s] && (tag_r[idx1_s] == tagq_s);
  assign hit_s         = hit0_s || hit1_s;
  assign hit_way_s     = hit1_s;
  // Fill empty ways first (way0 before way1); only evict by LRU when both are valid.
  assign victim_s      = !valid_r[idx0_s] ? 1'b0 : (!valid_r[idx1_s] ? 1'b1 : lru_r[set_s]);
  assign new_vic_idx_s = {set_s, victim_s};
  assign vic_idx_s     = {set_s, victim_r};
  assign last_s        = (cnt_r == CNT_W'(RAM_LAT - 1));

  assign state   = state_r;
  assign lru     = lru_r;
  assign valid_o = valid_r;
  assign dirty_o = dirty_r;

  // State machine and metadata update.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      addr_q_r  <= {ADDR_W{1'b0}};
      write_q_r <= 1'b0;
      miss_r    <= 1'b0;
      victim_r  <= 1'b0;
      hit_way_r <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
      valid_r   <= 8'd0;
      dirty_r   <= 8'd0;
      lru_r     <= 4'd0;
      for (int i = 0; i < 8; i++) tag_r[i] <= {TAG_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.req_valid) begin
            addr_q_r  <= bus.req_addr;
            write_q_r <= bus.req_write;
            miss_r    <= 1'b0;
            state_r   <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit_s) begin
            if (write_q_r) dirty_r[{set_s, hit_way_s}] <= 1'b1;
            lru_r[set_s] <= ~hit_way_s;
            hit_way_r    <= hit_way_s;
            state_r      <= RESP;
          end else begin
            miss_r   <= 1'b1;
            victim_r <= victim_s;
            cnt_r    <= {CNT_W{1'b0}};
            state_r  <= (valid_r[new_vic_idx_s] && dirty_r[new_vic_idx_s]) ? WB : FILL;
          end
        end
        WB: begin
          dirty_r[vic_idx_s] <= 1'b0;
          state_r            <= FILL;
        end
        FILL: begin
          if (last_s) begin
            tag_r[vic_idx_s]   <= tagq_s;
            valid_r[vic_idx_s] <= 1'b1;
            dirty_r[vic_idx_s] <= 1'b0;
            state_r            <= LOOKUP;   // replay; now hits
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        RESP: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Per-state decode of array, RAM and handshake controls.
  always_comb begin
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_hit   = 1'b0;
    arr_we         = 1'b0;
    arr_src        = 1'b0;
    arr_set        = set_s;
    arr_way        = 1'b0;
    ram_addr       = {ADDR_W{1'b0}};
    ram_wren       = 1'b0;
    case (state_r)
      IDLE: begin
        bus.req_ready = 1'b1;
      end
      LOOKUP: begin
        if (hit_s) begin
          arr_way = hit_way_s;
          arr_we  = write_q_r;
        end else begin
          arr_way = victim_s;
        end
      end
      WB: begin
        arr_way  = victim_r;
        ram_addr = {tag_r[vic_idx_s], set_s};
        ram_wren = 1'b1;
      end
      FILL: begin
        arr_way  = victim_r;
        ram_addr = {tagq_s, set_s};
        if (last_s) begin
          arr_we  = 1'b1;
          arr_src = 1'b1;
        end else begin
          arr_we  = 1'b0;
        end
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_hit   = ~miss_r;
        arr_way        = hit_way_r;
      end
      default: begin
        bus.req_ready = 1'b0;
      end
    endcase
  end

  assign write_back = ram_wren;
endmodule

// File: tb/tb_cache_ctrl_2way.sv
// Directed, table-driven bench for cache_ctrl_2way (RAM_LAT = 2).
module tb_cache_ctrl_2way;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       arr_we, arr_src, arr_way, ram_wren, write_back;
  logic [1:0] arr_set;
  logic [4:0] ram_addr;
  logic [2:0] state;
  logic [3:0] lru;
  logic [7:0] valid_o, dirty_o;

  cache_ctrl_2way_if #(.ADDR_W(5)) bus_if ();

  cache_ctrl_2way #(.RAM_LAT(2), .ADDR_W(5)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus_if),
    .arr_we(arr_we), .arr_src(arr_src), .arr_set(arr_set), .arr_way(arr_way),
    .ram_addr(ram_addr), .ram_wren(ram_wren), .write_back(write_back),
    .state(state), .lru(lru), .valid_o(valid_o), .dirty_o(dirty_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       wr;
    logic [4:0] addr;
    logic       hit;
    int         lat;
    int         wbs;
    logic [4:0] wb_addr;
    logic       way;
    int         cpu_we;
    int         fills;
    logic [7:0] valid;
    logic [7:0] dirty;
    logic [3:0] lru;
  } vec_t;

  vec_t vecs [8];
  int   n_pass = 0;
  int   n_total = 0;

  // results of the last do_req
  int         r_lat, r_wbs, r_cpu_we, r_fills, r_wb_mis;
  logic       r_hit, r_way;
  logic [4:0] r_wb_addr;
  logic [2:0] r_trace [16];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Issue one request from IDLE (called #1 after a posedge) and follow it to RESP.
  task automatic do_req(input logic wr, input logic [4:0] addr);
    int cyc;
    r_wbs = 0; r_cpu_we = 0; r_fills = 0; r_wb_mis = 0; r_lat = -1;
    r_hit = 1'b0; r_way = 1'b0; r_wb_addr = 5'd0;
    for (int i = 0; i < 16; i++) r_trace[i] = 3'd7;
    chk("ready_before_req", int'(bus_if.req_ready), 1);
    bus_if.req_valid = 1'b1;
    bus_if.req_write = wr;
    bus_if.req_addr  = addr;
    @(posedge clock); #1;
    bus_if.req_valid = 1'b0;
    cyc = 1;
    while (cyc < 16) begin
      r_trace[cyc] = state;
      if (ram_wren) begin r_wbs++; r_wb_addr = ram_addr; end
      if (ram_wren != write_back) r_wb_mis++;
      if (arr_we && !arr_src && state == 3'd1) r_cpu_we++;
      if (arr_we && arr_src) r_fills++;
      if (bus_if.resp_valid) begin
        r_lat = cyc; r_hit = bus_if.resp_hit; r_way = arr_way;
        break;
      end
      @(posedge clock); #1;
      cyc++;
    end
    if (r_lat < 0) $display("FAIL resp_timeout: got no resp_valid expected one within 15 cycles");
    @(posedge clock); #1;   // RESP -> IDLE
  endtask

  logic [4:0] bb_addr [4];
  logic       bb_hit  [4];

  initial begin
    int nacc, nresp, idx;
    logic acc;
    bus_if.req_valid = 1'b0;
    bus_if.req_write = 1'b0;
    bus_if.req_addr  = 5'd0;

    //        wr    addr      hit   lat wbs wb_addr  way  cpuwe fills valid  dirty  lru
    vecs[0] = '{1'b0, 5'b00101, 1'b0, 5, 0, 5'b00000, 1'b0, 0, 1, 8'h04, 8'h00, 4'h2};
    vecs[1] = '{1'b0, 5'b00101, 1'b1, 2, 0, 5'b00000, 1'b0, 0, 0, 8'h04, 8'h00, 4'h2};
    vecs[2] = '{1'b1, 5'b00101, 1'b1, 2, 0, 5'b00000, 1'b0, 1, 0, 8'h04, 8'h04, 4'h2};
    vecs[3] = '{1'b0, 5'b01001, 1'b0, 5, 0, 5'b00000, 1'b1, 0, 1, 8'h0C, 8'h04, 4'h0};
    vecs[4] = '{1'b0, 5'b01101, 1'b0, 6, 1, 5'b00101, 1'b0, 0, 1, 8'h0C, 8'h00, 4'h2};
    vecs[5] = '{1'b0, 5'b01101, 1'b1, 2, 0, 5'b00000, 1'b0, 0, 0, 8'h0C, 8'h00, 4'h2};
    vecs[6] = '{1'b0, 5'b01001, 1'b1, 2, 0, 5'b00000, 1'b1, 0, 0, 8'h0C, 8'h00, 4'h0};
    vecs[7] = '{1'b1, 5'b10010, 1'b0, 5, 0, 5'b00000, 1'b0, 1, 1, 8'h1C, 8'h10, 4'h4};

    // reset state
    #2;
    chk("rst_state", int'(state), 0);
    chk("rst_req_ready", int'(bus_if.req_ready), 1);
    chk("rst_resp_valid", int'(bus_if.resp_valid), 0);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_dirty", int'(dirty_o), 0);
    chk("rst_lru", int'(lru), 0);
    chk("rst_arr_we", int'(arr_we), 0);
    chk("rst_ram_wren", int'(ram_wren), 0);
    chk("rst_ram_addr", int'(ram_addr), 0);
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 8; i++) begin
      do_req(vecs[i].wr, vecs[i].addr);
      chk($sformatf("v%0d_latency", i), r_lat, vecs[i].lat);
      chk($sformatf("v%0d_resp_hit", i), int'(r_hit), int'(vecs[i].hit));
      chk($sformatf("v%0d_arr_way", i), int'(r_way), int'(vecs[i].way));
      chk($sformatf("v%0d_wb_cycles", i), r_wbs, vecs[i].wbs);
      chk($sformatf("v%0d_wb_eq_wren", i), r_wb_mis, 0);
      chk($sformatf("v%0d_cpu_we", i), r_cpu_we, vecs[i].cpu_we);
      chk($sformatf("v%0d_fills", i), r_fills, vecs[i].fills);
      chk($sformatf("v%0d_valid_o", i), int'(valid_o), int'(vecs[i].valid));
      chk($sformatf("v%0d_dirty_o", i), int'(dirty_o), int'(vecs[i].dirty));
      chk($sformatf("v%0d_lru", i), int'(lru), int'(vecs[i].lru));
      if (vecs[i].wbs != 0) chk($sformatf("v%0d_wb_addr", i), int'(r_wb_addr), int'(vecs[i].wb_addr));
      if (i == 0) begin
        chk("trace_c1", int'(r_trace[1]), 1);
        chk("trace_c2", int'(r_trace[2]), 3);
        chk("trace_c3", int'(r_trace[3]), 3);
        chk("trace_c4", int'(r_trace[4]), 1);
        chk("trace_c5", int'(r_trace[5]), 4);
      end
      if (i == 4) chk("v4_trace_wb", int'(r_trace[2]), 2);
    end

    // reset asserted in the middle of a fill
    bus_if.req_valid = 1'b1; bus_if.req_write = 1'b0; bus_if.req_addr = 5'b11111;
    @(posedge clock); #1;
    bus_if.req_valid = 1'b0;
    chk("mid_lookup", int'(state), 1);
    @(posedge clock); #1;
    chk("mid_fill", int'(state), 3);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_state", int'(state), 0);
    chk("mid_rst_valid", int'(valid_o), 0);
    chk("mid_rst_dirty", int'(dirty_o), 0);
    chk("mid_rst_wren", int'(ram_wren), 0);
    chk("mid_rst_resp", int'(bus_if.resp_valid), 0);
    @(posedge clock); #1;
    chk("mid_rst_hold_resp", int'(bus_if.resp_valid), 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    do_req(1'b0, 5'b00101);
    chk("post_rst_latency", r_lat, 5);
    chk("post_rst_hit", int'(r_hit), 0);
    chk("post_rst_valid", int'(valid_o), 8'h04);

    // req_valid held high across back-to-back requests
    bb_addr[0] = 5'b00101; bb_hit[0] = 1'b1;
    bb_addr[1] = 5'b00101; bb_hit[1] = 1'b1;
    bb_addr[2] = 5'b00001; bb_hit[2] = 1'b0;
    bb_addr[3] = 5'b00101; bb_hit[3] = 1'b1;
    nacc = 0; nresp = 0; idx = 0;
    bus_if.req_valid = 1'b1; bus_if.req_write = 1'b0; bus_if.req_addr = bb_addr[0];
    for (int c = 0; c < 60 && nresp < 4; c++) begin
      acc = bus_if.req_ready & bus_if.req_valid;
      @(posedge clock); #1;
      if (acc) begin
        nacc++; idx++;
        if (idx < 4) bus_if.req_addr = bb_addr[idx];
        else bus_if.req_valid = 1'b0;
      end
      if (bus_if.resp_valid) begin
        if (nresp < 4) chk($sformatf("bb%0d_hit", nresp), int'(bus_if.resp_hit), int'(bb_hit[nresp]));
        nresp++;
      end
    end
    bus_if.req_valid = 1'b0;
    chk("bb_accepts", nacc, 4);
    chk("bb_responses", nresp, 4);
    chk("bb_valid", int'(valid_o), 8'h0C);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/cache_ctrl_2way.md
Name: cache_ctrl_2way

Overview:
- FSM controller sequencing a 2-way set-associative, write-back, write-allocate cache in front of the single-port RAM. Address is 5 bits: tag = addr[4:2], set = addr[1:0], 4 sets x 2 ways, 3-bit data.
- Owns all metadata (tag, valid, dirty, per-set LRU bit).
- Drives the cache data-array and RAM control. Data words themselves flow through the existing datapath muxes, not through this block.
- Single requester (CPU side), valid/ready request, one-cycle response pulse.

Parameters:
RAM_LAT, 2, cycles from RAM read address presented to q valid (>=1)
ADDR_W, 5, address width; TAG_W = ADDR_W-2

Ports:
clock  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
req_valid  input  1  CPU request present
req_write  input  1  1 = write, 0 = read
req_addr  input  5  request address
req_ready  output  1  high only in IDLE; request accepted when req_valid & req_ready
resp_valid  output  1  one-cycle pulse, request complete
resp_hit  output  1  with resp_valid: 1 if first lookup hit
arr_we  output  1  data-array write enable
arr_src  output  1  array write source: 0 = CPU data_in, 1 = RAM q
arr_set  output  2  data-array set select
arr_way  output  1  data-array way select (also read-out way)
ram_addr  output  5  RAM address
ram_wren  output  1  RAM write enable (write-back); write data = array[arr_set][arr_way]
write_back  output  1  equals ram_wren
state  output  3  IDLE=0, LOOKUP=1, WB=2, FILL=3, RESP=4
lru  output  4  per-set LRU bit (way to evict next)
valid_o  output  8  {set3w1,set3w0,...,set0w0}
dirty_o  output  8  same packing

Behaviour:
- Reset (async, reset_n=0): state=IDLE; all valid, dirty, lru, tags = 0. Outputs: req_ready=1, all others 0. Applies mid-operation; no RAM write completes after reset asserts.
- IDLE: req_ready=1. On accept, latch addr and write; clear miss flag; -> LOOKUP. arr_we=ram_wren=0.
- LOOKUP (1 cycle): hit = valid[set][w] & tag[set][w]==tag_q, for either way (both ways never match).
  - Hit: arr_set=set, arr_way=w.
    - If write: arr_we=1, arr_src=0, dirty[set][w]<=1.
    - lru[set]<=~w.
    - -> RESP.
  - Miss: set miss flag. Victim = way0 if invalid, else way1 if invalid, else lru[set].
    - -> WB if victim valid & dirty, else -> FILL.
- WB (1 cycle): ram_addr={tag[set][victim],set}, ram_wren=1, arr_set/arr_way=victim; dirty[set][victim]<=0; -> FILL.
- FILL (RAM_LAT cycles, counter from 0): ram_addr={tag_q,set}, ram_wren=0.
  - On final count: arr_we=1, arr_src=1 at victim; tag<=tag_q, valid<=1, dirty<=0.
  - -> LOOKUP, which replays and now hits; a write is applied there.
- RESP (1 cycle): resp_valid=1, resp_hit=~miss flag, arr_set/arr_way hold the hit way (datapath read-out valid); -> IDLE.
- Latency from accept edge: read/write hit resp_valid at cycle +2. Clean miss: +3+RAM_LAT. Dirty miss: +4+RAM_LAT.
- req_valid outside IDLE is ignored (req_ready=0); requester must hold it.
- LRU updated only on LOOKUP hit; the replay after fill counts as the access.
- No undefined states: any unused encoding -> IDLE.

Test Plan:
- Reset then read 5'b00101 (RAM_LAT=2) -> state 1,3,3,1,4; resp_valid at cycle +5, resp_hit=0; valid_o[2]=1, lru[1]=1.
- Repeat read 5'b00101 -> resp_valid at +2, resp_hit=1, no ram_wren, arr_way=0.
- Write 5'b00101 (hit) -> arr_we=1, arr_src=0 in LOOKUP; dirty_o[2]=1; resp_hit=1 at +2.
- Then read 5'b01001 (fills way1, lru[1]=0), then read 5'b01101 -> WB state with ram_addr=5'b00101, write_back=1 one cycle; resp at +6, resp_hit=0; dirty_o[2]=0; tag way0 set1 = 3'b011.
- Assert reset_n=0 during FILL -> immediately state=0, valid_o=dirty_o=0, ram_wren=0, no resp_valid; after release a new request is accepted normally.
- Hold req_valid high continuously with back-to-back addresses -> exactly one accept per IDLE visit; no request dropped or duplicated.
